data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised byte-addressable data memory for the RV32I core; next generation of the basic single-port data memory.
- Adds RISC-V sub-word load/store (funct3-encoded), byte-lane writes, sign/zero extension, alignment and range checking, and a post-reset zero-clear sweep.
- Sits between the ALU result/rs2 path and the writeback mux.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- INIT_CLEAR, 1, 1 = zero the whole array after reset before accepting accesses; 0 = no sweep, contents undefined after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- we  in  1  write enable (store).
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- A  in  32  byte address.
- WD  in  32  store data; low byte or half used for B/H.
- RD  out  32  load data, extended to 32 bits.
- ready  out  1  high when the memory accepts accesses.
- misaligned  out  1  H/HU access with A[0]=1, or W access with A[1:0]!=0.
- access_fault  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH), or illegal funct3 (011, 110, 111).

Behaviour:
- Address decode: off = A - BASE_ADDR; word index = off[AW+1:2], where AW = clog2(DEPTH); lane = A[1:0].
- Reset (rst_n=0 at a rising edge):
  - ready=0, RD=0, misaligned=0, access_fault=0.
  - Clear pointer = 0.
  - State = CLEAR if INIT_CLEAR=1, else RUN.
- FSM states: CLEAR and RUN.
  - CLEAR: each cycle writes 0 to word[ptr], then ptr++. After writing word DEPTH-1, moves to RUN; the sweep takes exactly DEPTH cycles after reset release.
  - During CLEAR: ready=0, external writes ignored, RD=0, flags=0.
  - RUN: ready=1; stays in RUN until reset.
- Reset asserted mid-sweep: the sweep restarts from ptr=0 after release.
- Loads (combinational in RUN):
  - RD is selected from word[index] by lane.
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - If misaligned or access_fault: RD=0.
- Stores: on a rising edge with we=1, ready=1, misaligned=0 and access_fault=0:
  - B: writes lane byte = WD[7:0].
  - H: writes lanes {A[1],0} and {A[1],1} with WD[15:0].
  - W: writes all 4 lanes.
  - Unselected lanes are unchanged.
- Suppressed store (misaligned, fault, or not ready): no array change; flags still reported.
- Flags are combinational from funct3 and A in RUN, and are independent of we.
- If both conditions hold, misaligned and access_fault are both 1.
- Read-during-write to the same word: RD shows old data until the edge and new data after it.
- Writes at the top word (index DEPTH-1) do not wrap to index 0. Out-of-range addresses always fault.

Optional Feature:
- Macro: DMEM_RD_REG_EN.
- Defined:
  - RD, misaligned and access_fault are registered, giving 1-cycle load latency from A/funct3.
  - Same-cycle read and write to the same word returns old data (read-first).
  - Registers reset to 0 and hold 0 during CLEAR.
- Undefined: fully combinational read path, as described in Behaviour.

Test Plan:
- Reset clear, DEPTH=16, INIT_CLEAR=1:
  - Release rst_n -> ready=0 for exactly 16 cycles, then 1.
  - LW at every word returns 0.
  - A store issued during CLEAR has no effect.
- Byte store/load:
  - SW 0x11223344 @0x8, then SB 0xA5 @0x9 -> LW @0x8 = 0x1122A544.
  - LB @0x9 = 0xFFFFFFA5; LBU @0x9 = 0x000000A5.
- Halfword store/load:
  - SH 0x8001 @0xE -> LH @0xE = 0xFFFF8001; LHU @0xE = 0x00008001.
  - LW @0xC has the upper half = 0x8001, lower half unchanged.
- Misalignment:
  - SW @0x6 -> misaligned=1, memory unchanged; LW @0x6 -> RD=0.
  - LH @0x3 -> misaligned=1; LB @0x3 -> misaligned=0.
- Range and illegal funct3:
  - A = BASE_ADDR + 4*DEPTH -> access_fault=1, store suppressed, RD=0.
  - funct3=011 at a valid address -> access_fault=1.
- Reset mid-sweep and optional register:
  - Assert rst_n low at sweep cycle 5 -> ready rises a full DEPTH cycles after the new release.
  - With DMEM_RD_REG_EN defined, RD follows the address one cycle later.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32I data memory: funct3 sub-word loads/stores, range/alignment checks, post-reset zero sweep.
// Latency: combinational load path, or 1 cycle when DMEM_RD_REG_EN is defined; stores commit on the rising edge.
// Backpressure: ready stays low through the clear sweep, and stores or loads issued then are dropped.
module data_memory_ctrl #(
    parameter int          DEPTH      = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          INIT_CLEAR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        ready,
    output logic        misaligned,
    output logic        access_fault
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic [0:0] {CLEAR, RUN} state_t;

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [AW-1:0] ptr;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          legal;
    logic          mis_c;
    logic          fault_c;
    logic [31:0]   word;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   rd_c;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic          st_en;

    // Modular subtraction: addresses below BASE_ADDR wrap high and fail the range compare.
    assign off      = A - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign in_range = ({1'b0, off} < SPAN);
    assign word     = mem[idx];

    always_comb begin
        legal = 1'b0;
        mis_c = 1'b0;
        case (funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: begin legal = 1'b1; mis_c = A[0]; end
            3'b010:         begin legal = 1'b1; mis_c = |A[1:0]; end
            default:        legal = 1'b0;
        endcase
        fault_c = !legal || !in_range;

        case (A[1:0])
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = A[1] ? word[31:16] : word[15:0];

        case (funct3)
            3'b000:  rd_c = {{24{byte_v[7]}}, byte_v};
            3'b100:  rd_c = {24'd0, byte_v};
            3'b001:  rd_c = {{16{half_v[15]}}, half_v};
            3'b101:  rd_c = {16'd0, half_v};
            3'b010:  rd_c = word;
            default: rd_c = 32'd0;
        endcase
        if (!ready || mis_c || fault_c)
            rd_c = 32'd0;

        case (funct3[1:0])
            2'b00:   begin be = 4'b0001 << A[1:0];             wdat = {4{WD[7:0]}};  end
            2'b01:   begin be = A[1] ? 4'b1100 : 4'b0011;      wdat = {2{WD[15:0]}}; end
            default: begin be = 4'b1111;                       wdat = WD;            end
        endcase
    end

    assign st_en = rst_n && we && ready && !mis_c && !fault_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : RUN;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: ready <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (st_en) begin
            for (int l = 0; l < 4; l++)
                if (be[l])
                    mem[idx][8*l +: 8] <= wdat[8*l +: 8];
        end
    end

`ifdef DMEM_RD_REG_EN
    // Sampled on the same edge as any store, so a same-word access returns the pre-store word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RD           <= '0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            RD           <= rd_c;
            misaligned   <= ready && mis_c;
            access_fault <= ready && fault_c;
        end
    end
`else
    assign RD           = rd_c;
    assign misaligned   = ready && mis_c;
    assign access_fault = ready && fault_c;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (DEPTH=16, BASE_ADDR=0, INIT_CLEAR=1); handles both read-path builds.
module tb_data_memory_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        ready;
    logic        misaligned;
    logic        access_fault;

    int tests_run    = 0;
    int tests_failed = 0;
    int cnt;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    data_memory_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .INIT_CLEAR(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .funct3(funct3), .A(A), .WD(WD),
        .RD(RD), .ready(ready), .misaligned(misaligned), .access_fault(access_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: drive at negedge, then sample where the result is visible in this build.
    task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; funct3 = f3; A = a; WD = d;
`ifdef DMEM_RD_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; funct3 = F_W; A = 32'h6; WD = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rd", RD, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_fault", {31'd0, access_fault}, 32'd0);

        A = 32'h0;
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("sweep_cycles", cnt, 32'd16);

        // byte store/load
        op(1, F_W, 32'h8, 32'h1122_3344);
        op(1, F_B, 32'h9, 32'h0000_00A5);
        op(0, F_W, 32'h8, 0);  check("lw_after_sb", RD, 32'h1122_A544);
        op(0, F_B, 32'h9, 0);  check("lb", RD, 32'hFFFF_FFA5);
        op(0, F_BU, 32'h9, 0); check("lbu", RD, 32'h0000_00A5);

        // halfword store/load
        op(1, F_W, 32'hC, 32'h5566_7788);
        op(1, F_H, 32'hE, 32'h0000_8001);
        op(0, F_H, 32'hE, 0);  check("lh", RD, 32'hFFFF_8001);
        op(0, F_HU, 32'hE, 0); check("lhu", RD, 32'h0000_8001);
        op(0, F_W, 32'hC, 0);  check("lw_after_sh", RD, 32'h8001_7788);

        // misalignment
        op(1, F_W, 32'h4, 32'hCAFE_BABE);
        op(1, F_W, 32'h6, 32'h1234_5678);
        check("sw6_mis", {31'd0, misaligned}, 32'd1);
        check("sw6_fault", {31'd0, access_fault}, 32'd0);
        check("sw6_rd", RD, 32'd0);
        op(0, F_W, 32'h4, 0);  check("w4_unchanged", RD, 32'hCAFE_BABE);
        op(0, F_H, 32'h3, 0);  check("lh3_mis", {31'd0, misaligned}, 32'd1);
        op(0, F_B, 32'h3, 0);  check("lb3_mis", {31'd0, misaligned}, 32'd0);
        op(0, F_B, 32'h7, 0);  check("lb7", RD, 32'hFFFF_FFCA);
        op(0, F_HU, 32'h6, 0); check("lhu6", RD, 32'h0000_CAFE);

        // range and illegal funct3
        op(1, F_W, 32'h3C, 32'h0F0F_0F0F);
        op(1, F_W, 32'h40, 32'hFFFF_FFFF);
        check("oor_fault", {31'd0, access_fault}, 32'd1);
        check("oor_mis", {31'd0, misaligned}, 32'd0);
        check("oor_rd", RD, 32'd0);
        op(0, F_W, 32'h0, 0);  check("w0_no_wrap", RD, 32'd0);
        op(0, F_W, 32'h3C, 0); check("top_word", RD, 32'h0F0F_0F0F);
        op(0, 3'b011, 32'h8, 0);
        check("f011_fault", {31'd0, access_fault}, 32'd1);
        check("f011_rd", RD, 32'd0);
        op(0, 3'b110, 32'h8, 0); check("f110_fault", {31'd0, access_fault}, 32'd1);
        op(0, F_W, 32'h42, 0);
        check("both_mis", {31'd0, misaligned}, 32'd1);
        check("both_fault", {31'd0, access_fault}, 32'd1);
        op(0, F_W, 32'h8, 0);  check("valid_no_fault", {31'd0, access_fault}, 32'd0);

        // read-during-write shows old data, then new data
        op(1, F_W, 32'h8, 32'h9999_9999); check("rdw_old", RD, 32'h1122_A544);
        op(0, F_W, 32'h8, 0);             check("rdw_new", RD, 32'h9999_9999);

        // fill all words, then reset mid-sweep with a store attempt during the sweep
        for (int i = 0; i < DEPTH; i++)
            op(1, F_W, 32'(i * 4), 32'h5A00_0000 | 32'(i));
        op(0, F_W, 32'h14, 0); check("fill_w5", RD, 32'h5A00_0005);

        @(negedge clk);
        we = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midsweep_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin
            if (cnt == 3) begin we = 1'b1; funct3 = F_W; A = 32'h0; WD = 32'hDEAD_BEEF; end
            if (cnt == 5) we = 1'b0;
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        we = 1'b0;
        check("resweep_cycles", cnt, 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            op(0, F_W, 32'(i * 4), 0);
            check($sformatf("clear_w%0d", i), RD, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
